vector_comparison_arbiter: RTL and testbench
============================================

VECTOR_COMPARISON_ARBITER -- requirements
Module: vector_comparison_arbiter

Interface
REQ-001 The block SHALL have parameter TAG_WIDTH, default 4, setting the width of the request/result tag.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have ports reqN_valid_i, input, 1, request N valid, for N = 0,1.
REQ-005 The block SHALL have ports reqN_ready_o, output, 1, request N accepted this cycle.
REQ-006 The block SHALL have ports reqN_operand_A_i and reqN_operand_B_i, input, vector_t (32), operands.
REQ-007 The block SHALL have ports reqN_esize_i (esize_t), reqN_operation_i (vcomp_operation_t), reqN_signed_i (1) and reqN_tag_i (TAG_WIDTH), all inputs.
REQ-008 The block SHALL have ports unit_operand_A_o, unit_operand_B_o, unit_element_size_o, unit_operation_o, unit_signed_o and unit_data_valid_o, all outputs, driving the comparison unit.
REQ-009 The block SHALL have ports unit_result_i (vector_t) and unit_data_valid_i (1), inputs, returned combinationally by the unit.
REQ-010 The block SHALL have output ports for the registered result:
- result_o (vector_t)
- result_tag_o (TAG_WIDTH)
- result_source_o (1): requester index
- result_illegal_o (1)
- result_valid_o (1)
REQ-011 The block SHALL have port result_ready_i, input, 1, consumer accepts result.
REQ-012 The block SHALL have port flush_i, input, 1, discard the held result and block issue this cycle.

Function
REQ-013 The output slot SHALL be free when result_valid_o=0, or when result_valid_o=1 and result_ready_i=1.
REQ-014 A grant SHALL occur only when the slot is free, flush_i=0 and at least one reqN_valid_i=1; at most one grant per cycle.
REQ-015 Arbitration SHALL be round-robin via a 1-bit priority pointer:
- both requesters valid: the pointed requester wins;
- one requester valid: it wins regardless of the pointer.
REQ-016 After each grant the pointer SHALL point to the non-granted requester; without a grant it SHALL hold.
REQ-017 reqN_ready_o SHALL be 1 only for the granted requester in the grant cycle, combinationally.
REQ-018 unit_* operand/control outputs SHALL mirror the granted request; unit_data_valid_o SHALL equal the grant; with no grant all unit_* outputs SHALL be 0.
REQ-019 On a grant the block SHALL capture the following on the next edge and set result_valid_o=1:
- unit_result_i into result_o;
- the request tag into result_tag_o;
- the requester index into result_source_o.
Latency is 1 cycle from acceptance to result_valid_o.
REQ-020 A grant whose element size is neither BIT16 nor BIT8 SHALL still be accepted; the captured result SHALL be result_o=0 and result_illegal_o=1. Otherwise result_illegal_o=0.
REQ-021 If unit_data_valid_i=0 in a grant cycle, the block SHALL capture result_o=0 with result_illegal_o=1.
REQ-022 result_o, result_tag_o, result_source_o and result_illegal_o SHALL remain stable while result_valid_o=1 and result_ready_i=0.
REQ-023 Drain with no grant (result_valid_o=1, result_ready_i=1, no grant) SHALL clear result_valid_o next cycle.
REQ-024 Simultaneous drain and grant SHALL replace the slot contents with result_valid_o staying 1, giving 1 result/cycle throughput.
REQ-025 Flush SHALL clear result_valid_o next cycle and produce no grant that cycle; flush and result_ready_i together SHALL count as a flush, with no handshake.
REQ-026 Requests not granted SHALL hold their inputs stable; the block SHALL NOT latch request inputs.

Reset
REQ-027 While rst_i=1 and on the following edge, the block SHALL hold:
- result_valid_o=0, result_o=0, result_tag_o=0, result_source_o=0, result_illegal_o=0;
- priority pointer=0, so requester 0 is favoured first.
REQ-028 Reset asserted mid-transaction SHALL discard the held result immediately (asynchronously); reqN_ready_o and unit_data_valid_o SHALL be 0 during reset.

Verification
REQ-029 Scenario: req0 EQL BIT16, A=0x12345678, B=0x12340000, tag=3 -> next cycle result_o=0xFFFF0000, result_tag_o=3, result_source_o=0, result_valid_o=1.
REQ-030 Scenario: req1 MAX BIT8 signed, A=0x80017FFF, B=0x00027EFF -> result_o=0x00027FFF, result_source_o=1.
REQ-031 Scenario: both requesters valid continuously, result_ready_i=1, after reset -> grants alternate 0,1,0,1; one result per cycle, no gaps.
REQ-032 Scenario: result_ready_i=0 for 3 cycles with both requesters valid -> one grant only, result held stable, both ready_o low; the grant resumes on the same cycle result_ready_i rises.
REQ-033 Scenario: req0 with esize BIT32 -> accepted, result_o=0, result_illegal_o=1.
REQ-034 Scenario: flush_i and req0_valid_i asserted with result pending -> req0_ready_o=0, result_valid_o=0 next cycle; then rst_i pulsed mid-hold -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/vector_comparison_arbiter.sv
// Two-requester round-robin front end for a vector comparison unit.
// One request is issued per cycle into a single registered result slot.
package vcomp_pkg;
  typedef logic [31:0] vector_t;
  typedef enum logic [1:0] {BIT32 = 2'd0, BIT16 = 2'd1, BIT8 = 2'd2, BIT_RSVD = 2'd3} esize_t;
  typedef enum logic [2:0] {EQL, NEQ, LTH, LEQ, GTH, GEQ, MAX, MIN} vcomp_operation_t;
  typedef struct packed {
    vector_t          a;
    vector_t          b;
    esize_t           esize;
    vcomp_operation_t op;
    logic             sgn;
  } vreq_t;
endpackage

module vector_comparison_arbiter
  import vcomp_pkg::*;
#(
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  vector_t              req0_operand_A_i,
  input  vector_t              req0_operand_B_i,
  input  esize_t               req0_esize_i,
  input  vcomp_operation_t     req0_operation_i,
  input  logic                 req0_signed_i,
  input  logic [TAG_WIDTH-1:0] req0_tag_i,
  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  vector_t              req1_operand_A_i,
  input  vector_t              req1_operand_B_i,
  input  esize_t               req1_esize_i,
  input  vcomp_operation_t     req1_operation_i,
  input  logic                 req1_signed_i,
  input  logic [TAG_WIDTH-1:0] req1_tag_i,
  output vector_t              unit_operand_A_o,
  output vector_t              unit_operand_B_o,
  output esize_t               unit_element_size_o,
  output vcomp_operation_t     unit_operation_o,
  output logic                 unit_signed_o,
  output logic                 unit_data_valid_o,
  input  vector_t              unit_result_i,
  input  logic                 unit_data_valid_i,
  output vector_t              result_o,
  output logic [TAG_WIDTH-1:0] result_tag_o,
  output logic                 result_source_o,
  output logic                 result_illegal_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  input  logic                 flush_i
);

  vreq_t                w_req [2];
  logic [TAG_WIDTH-1:0] w_tag [2];
  logic [1:0]           w_valid;
  vreq_t                w_gnt;
  logic                 w_slot_free, w_grant, w_sel, w_ok;

  logic                 r_ptr;
  vector_t              r_result;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                 r_source, r_illegal, r_valid;

  always_comb begin
    w_req[0] = '{a: req0_operand_A_i, b: req0_operand_B_i, esize: req0_esize_i,
                 op: req0_operation_i, sgn: req0_signed_i};
    w_req[1] = '{a: req1_operand_A_i, b: req1_operand_B_i, esize: req1_esize_i,
                 op: req1_operation_i, sgn: req1_signed_i};
    w_tag[0] = req0_tag_i;
    w_tag[1] = req1_tag_i;
    w_valid  = {req1_valid_i, req0_valid_i};
  end

  // The pointer only matters on contention; a lone requester always wins.
  always_comb begin
    w_slot_free = !r_valid || result_ready_i;
    w_grant     = !rst_i && w_slot_free && !flush_i && (|w_valid);
    w_sel       = (&w_valid) ? r_ptr : w_valid[1];
    w_gnt       = w_grant ? w_req[w_sel] : '0;
    w_ok        = unit_data_valid_i && (w_gnt.esize == BIT16 || w_gnt.esize == BIT8);
  end

  assign req0_ready_o        = w_grant && !w_sel;
  assign req1_ready_o        = w_grant && w_sel;
  assign unit_operand_A_o    = w_gnt.a;
  assign unit_operand_B_o    = w_gnt.b;
  assign unit_element_size_o = w_gnt.esize;
  assign unit_operation_o    = w_gnt.op;
  assign unit_signed_o       = w_gnt.sgn;
  assign unit_data_valid_o   = w_grant;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr     <= 1'b0;
      r_result  <= '0;
      r_tag     <= '0;
      r_source  <= 1'b0;
      r_illegal <= 1'b0;
      r_valid   <= 1'b0;
    end else if (flush_i) begin
      r_valid   <= 1'b0;
    end else if (w_grant) begin
      r_ptr     <= !w_sel;
      r_result  <= w_ok ? unit_result_i : '0;
      r_tag     <= w_tag[w_sel];
      r_source  <= w_sel;
      r_illegal <= !w_ok;
      r_valid   <= 1'b1;
    end else if (r_valid && result_ready_i) begin
      r_valid   <= 1'b0;
    end
  end

  assign result_o         = r_result;
  assign result_tag_o     = r_tag;
  assign result_source_o  = r_source;
  assign result_illegal_o = r_illegal;
  assign result_valid_o   = r_valid;

endmodule

// File: tb/tb_vector_comparison_arbiter.sv
// Directed bench for vector_comparison_arbiter; the bench plays the comparison
// unit by driving hand-computed results onto unit_result_i.
module tb_vector_comparison_arbiter;
  import vcomp_pkg::*;

  logic clk = 1'b0, rst = 1'b0;
  logic v0 = 0, v1 = 0, s0 = 0, s1 = 0, rdy0, rdy1;
  vector_t a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  esize_t e0 = BIT16, e1 = BIT16;
  vcomp_operation_t op0 = EQL, op1 = EQL;
  logic [3:0] t0 = '0, t1 = '0;
  vector_t u_a, u_b, u_res = '0, res;
  esize_t u_es;
  vcomp_operation_t u_op;
  logic u_sgn, u_dv_o, u_dv_i = 1'b1;
  logic [3:0] rtag;
  logic rsrc, rill, rvld, rrdy = 1'b1, flush = 1'b0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  vector_comparison_arbiter #(.TAG_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_operand_A_i(a0), .req0_operand_B_i(b0),
    .req0_esize_i(e0), .req0_operation_i(op0), .req0_signed_i(s0), .req0_tag_i(t0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_operand_A_i(a1), .req1_operand_B_i(b1),
    .req1_esize_i(e1), .req1_operation_i(op1), .req1_signed_i(s1), .req1_tag_i(t1),
    .unit_operand_A_o(u_a), .unit_operand_B_o(u_b), .unit_element_size_o(u_es),
    .unit_operation_o(u_op), .unit_signed_o(u_sgn), .unit_data_valid_o(u_dv_o),
    .unit_result_i(u_res), .unit_data_valid_i(u_dv_i),
    .result_o(res), .result_tag_o(rtag), .result_source_o(rsrc),
    .result_illegal_o(rill), .result_valid_o(rvld),
    .result_ready_i(rrdy), .flush_i(flush)
  );

  task automatic test_reset();
    rst = 1'b1; v0 = 1'b1;
    @(negedge clk); #1;
    checks++; if (rvld !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", rvld); end
    checks++; if (res !== 32'h0) begin failures++; $display("FAIL rst_result got=%h exp=0", res); end
    checks++; if ({rtag, rsrc, rill} !== 6'h0) begin failures++; $display("FAIL rst_fields got=%h exp=0", {rtag, rsrc, rill}); end
    checks++; if ({rdy0, rdy1, u_dv_o} !== 3'b000) begin failures++; $display("FAIL rst_ready got=%b exp=000", {rdy0, rdy1, u_dv_o}); end
    @(negedge clk); rst = 1'b0; v0 = 1'b0;
  endtask

  task automatic test_eql();
    v0 = 1; a0 = 32'h12345678; b0 = 32'h12340000; e0 = BIT16; op0 = EQL; s0 = 0; t0 = 4'd3;
    u_res = 32'hFFFF0000; #1;
    checks++; if ({rdy0, rdy1} !== 2'b10) begin failures++; $display("FAIL eql_ready got=%b exp=10", {rdy0, rdy1}); end
    checks++; if (u_a !== 32'h12345678 || u_b !== 32'h12340000 || u_es !== BIT16 || u_dv_o !== 1'b1)
      begin failures++; $display("FAIL eql_unit got=%h/%h/%0d/%b exp=12345678/12340000/1/1", u_a, u_b, u_es, u_dv_o); end
    @(posedge clk); #1;
    checks++; if (res !== 32'hFFFF0000) begin failures++; $display("FAIL eql_result got=%h exp=ffff0000", res); end
    checks++; if ({rvld, rsrc, rill, rtag} !== 7'b1_0_0_0011) begin failures++; $display("FAIL eql_meta got=%b exp=1000011", {rvld, rsrc, rill, rtag}); end
    @(negedge clk); v0 = 0; #1;
    checks++; if (u_dv_o !== 1'b0 || u_a !== 32'h0) begin failures++; $display("FAIL idle_unit got=%b/%h exp=0/0", u_dv_o, u_a); end
    @(posedge clk); #1;
    checks++; if (rvld !== 1'b0) begin failures++; $display("FAIL eql_drain got=%0h exp=0", rvld); end
  endtask

  task automatic test_max();
    @(negedge clk);
    v1 = 1; a1 = 32'h80017FFF; b1 = 32'h00027EFF; e1 = BIT8; op1 = MAX; s1 = 1; t1 = 4'd9;
    u_res = 32'h00027FFF; #1;
    checks++; if ({rdy0, rdy1} !== 2'b01) begin failures++; $display("FAIL max_ready got=%b exp=01", {rdy0, rdy1}); end
    checks++; if (u_op !== MAX || u_sgn !== 1'b1 || u_b !== 32'h00027EFF) begin failures++; $display("FAIL max_unit got=%0d/%b/%h exp=6/1/00027eff", u_op, u_sgn, u_b); end
    @(posedge clk); #1;
    checks++; if (res !== 32'h00027FFF) begin failures++; $display("FAIL max_result got=%h exp=00027fff", res); end
    checks++; if ({rvld, rsrc, rill, rtag} !== 7'b1_1_0_1001) begin failures++; $display("FAIL max_meta got=%b exp=1101001", {rvld, rsrc, rill, rtag}); end
    @(negedge clk); v1 = 0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    rst = 1; #1; rst = 0;
    a0 = 32'h0A0A0A0A; a1 = 32'h1B1B1B1B; e0 = BIT8; e1 = BIT16; v0 = 1; v1 = 1;
    for (int k = 0; k < 4; k++) begin
      u_res = 32'hA0 + k; #1;
      checks++; if ({rdy0, rdy1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_ready[%0d] got=%b", k, {rdy0, rdy1}); end
      checks++; if (u_a !== ((k % 2 == 0) ? 32'h0A0A0A0A : 32'h1B1B1B1B)) begin failures++; $display("FAIL rr_unit_a[%0d] got=%h", k, u_a); end
      @(posedge clk); #1;
      checks++; if (rvld !== 1'b1 || rsrc !== k[0] || res !== 32'hA0 + k)
        begin failures++; $display("FAIL rr_result[%0d] got=%b/%b/%h exp=1/%b/%h", k, rvld, rsrc, res, k[0], 32'hA0 + k); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back_stall();
    rrdy = 0; u_res = 32'hDEAD;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({rdy0, rdy1, u_dv_o} !== 3'b000) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=000", k, {rdy0, rdy1, u_dv_o}); end
      @(posedge clk); #1;
      checks++; if (rvld !== 1'b1 || rsrc !== 1'b1 || res !== 32'hA3) begin failures++; $display("FAIL stall_hold[%0d] got=%b/%b/%h exp=1/1/a3", k, rvld, rsrc, res); end
      @(negedge clk);
    end
    rrdy = 1; #1;
    checks++; if ({rdy0, rdy1} !== 2'b10) begin failures++; $display("FAIL stall_resume got=%b exp=10", {rdy0, rdy1}); end
    @(posedge clk); #1;
    checks++; if (rvld !== 1'b1 || rsrc !== 1'b0 || res !== 32'hDEAD) begin failures++; $display("FAIL stall_after got=%b/%b/%h exp=1/0/dead", rvld, rsrc, res); end
    @(negedge clk); v0 = 0; v1 = 0;
  endtask

  task automatic test_illegal();
    v0 = 1; e0 = BIT32; u_res = 32'h1234; #1;
    checks++; if ({rdy0, rdy1} !== 2'b10) begin failures++; $display("FAIL ill_ready got=%b exp=10", {rdy0, rdy1}); end
    @(posedge clk); #1;
    checks++; if (res !== 32'h0 || rill !== 1'b1 || rvld !== 1'b1) begin failures++; $display("FAIL ill_esize got=%h/%b/%b exp=0/1/1", res, rill, rvld); end
    @(negedge clk); v0 = 0; v1 = 1; e1 = BIT8; u_dv_i = 0; u_res = 32'h5678;
    @(posedge clk); #1;
    checks++; if (res !== 32'h0 || rill !== 1'b1 || rsrc !== 1'b1) begin failures++; $display("FAIL ill_unitdv got=%h/%b/%b exp=0/1/1", res, rill, rsrc); end
    @(negedge clk); v1 = 0; v0 = 1; e0 = BIT8; u_dv_i = 1; u_res = 32'h55;
    @(posedge clk); #1;
    checks++; if (res !== 32'h55 || rill !== 1'b0) begin failures++; $display("FAIL ill_clear got=%h/%b exp=55/0", res, rill); end
    @(negedge clk);
  endtask

  task automatic test_flush_reset();
    flush = 1; rrdy = 1; v0 = 1; #1;
    checks++; if (rdy0 !== 1'b0 || u_dv_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b/%b exp=0/0", rdy0, u_dv_o); end
    @(posedge clk); #1;
    checks++; if (rvld !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", rvld); end
    @(negedge clk); flush = 0; rrdy = 0; t0 = 4'd7; u_res = 32'h77;
    @(posedge clk); #1;
    checks++; if (rvld !== 1'b1 || rtag !== 4'd7 || res !== 32'h77) begin failures++; $display("FAIL hold_load got=%b/%h/%h exp=1/7/77", rvld, rtag, res); end
    @(negedge clk); #2; rst = 1; #1;
    checks++; if ({rvld, rsrc, rill, rtag} !== 7'h0 || res !== 32'h0) begin failures++; $display("FAIL async_rst got=%b/%h exp=0/0", {rvld, rsrc, rill, rtag}, res); end
    checks++; if ({rdy0, u_dv_o} !== 2'b00) begin failures++; $display("FAIL async_rst_ready got=%b exp=00", {rdy0, u_dv_o}); end
    @(negedge clk); rst = 0; v0 = 0; rrdy = 1;
  endtask

  initial begin
    test_reset();
    test_eql();
    test_max();
    test_round_robin();
    test_back_to_back_stall();
    test_illegal();
    test_flush_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
